// File: rtl/icb_slave_bank.sv
// rtl/icb_slave_bank.sv - ICB slave decoding one window into config regs, a status reg and an SRAM port
module icb_slave_bank #(
  parameter logic [31:0]           BASE_HI = 32'h10042,
  parameter int                    WIN_AW  = 12,
  parameter int                    NUM_CFG = 2,
  parameter logic [32*NUM_CFG-1:0] CFG_RST = {32'h2, 32'h0},
  parameter int                    SRAM_AW = 10,
  parameter int                    RD_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   icb_cmd_valid,
  output logic                   icb_cmd_ready,
  input  logic                   icb_cmd_read,
  input  logic [31:0]            icb_cmd_addr,
  input  logic [31:0]            icb_cmd_wdata,
  input  logic [3:0]             icb_cmd_wmask,
  output logic                   icb_rsp_valid,
  input  logic                   icb_rsp_ready,
  output logic [31:0]            icb_rsp_rdata,
  output logic                   icb_rsp_err,
  output logic [32*NUM_CFG-1:0]  cfg_regs,
  output logic [NUM_CFG-1:0]     cfg_wr_pulse,
  input  logic [31:0]            status_in,
  output logic                   sram_wr_en,
  output logic [3:0]             sram_wr_be,
  output logic [SRAM_AW-1:0]     sram_wr_addr,
  output logic [31:0]            sram_wr_data,
  output logic                   sram_rd_en,
  output logic [SRAM_AW-1:0]     sram_rd_addr,
  input  logic [31:0]            sram_rd_data
);

  localparam logic [31:0] OFF_MASK   = (32'd1 << WIN_AW) - 32'd1;
  localparam logic [31:0] STATUS_OFF = 32'(4 * NUM_CFG);
  localparam logic [31:0] SRAM_BASE  = 32'(4 * (NUM_CFG + 1));
  localparam logic [31:0] SRAM_DEPTH = 32'd1 << SRAM_AW;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RSP} state_t;

  state_t      state;
  logic [2:0]  lat_cnt;
  logic [31:0] offset;
  logic [31:0] sram_idx;
  logic        in_win;
  logic        is_cfg;
  logic        is_status;
  logic        is_sram;
  logic        cmd_err;
  logic [31:0] cfg_rd_val;

  assign icb_cmd_ready = (state == IDLE);

  assign offset    = icb_cmd_addr & OFF_MASK;
  assign in_win    = (icb_cmd_addr >> WIN_AW) == BASE_HI;
  assign is_cfg    = offset < STATUS_OFF;
  assign is_status = offset == STATUS_OFF;
  assign is_sram   = offset >= SRAM_BASE;
  // Wraps for non-SRAM offsets; only consulted when is_sram is set.
  assign sram_idx  = (offset - SRAM_BASE) >> 2;
  assign cmd_err   = !in_win || (icb_cmd_addr[1:0] != 2'b00) ||
                     (is_sram && (sram_idx >= SRAM_DEPTH)) ||
                     (is_status && !icb_cmd_read);

  always_comb begin
    cfg_rd_val = '0;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (offset[31:2] == 30'(i)) cfg_rd_val = cfg_regs[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      lat_cnt       <= '0;
      cfg_regs      <= CFG_RST;
      cfg_wr_pulse  <= '0;
      icb_rsp_valid <= 1'b0;
      icb_rsp_err   <= 1'b0;
      icb_rsp_rdata <= '0;
      sram_wr_en    <= 1'b0;
      sram_wr_be    <= '0;
      sram_wr_addr  <= '0;
      sram_wr_data  <= '0;
      sram_rd_en    <= 1'b0;
      sram_rd_addr  <= '0;
    end else begin
      cfg_wr_pulse <= '0;
      sram_wr_en   <= 1'b0;
      sram_rd_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (icb_cmd_valid) begin
            if (cmd_err) begin
              icb_rsp_valid <= 1'b1;
              icb_rsp_err   <= 1'b1;
              icb_rsp_rdata <= '0;
              state         <= RSP;
            end else if (icb_cmd_read) begin
              if (is_sram) begin
                sram_rd_en   <= 1'b1;
                sram_rd_addr <= sram_idx[SRAM_AW-1:0];
                lat_cnt      <= '0;
                state        <= RD_WAIT;
              end else begin
                icb_rsp_rdata <= is_status ? status_in : cfg_rd_val;
                icb_rsp_err   <= 1'b0;
                icb_rsp_valid <= 1'b1;
                state         <= RSP;
              end
            end else begin
              if (is_sram) begin
                sram_wr_en   <= 1'b1;
                sram_wr_be   <= icb_cmd_wmask;
                sram_wr_addr <= sram_idx[SRAM_AW-1:0];
                sram_wr_data <= icb_cmd_wdata;
              end else if (is_cfg) begin
                for (int i = 0; i < NUM_CFG; i++) begin
                  if (offset[31:2] == 30'(i)) begin
                    cfg_wr_pulse[i] <= 1'b1;
                    for (int k = 0; k < 4; k++) begin
                      if (icb_cmd_wmask[k])
                        cfg_regs[32*i + 8*k +: 8] <= icb_cmd_wdata[8*k +: 8];
                    end
                  end
                end
              end
              icb_rsp_err   <= 1'b0;
              icb_rsp_valid <= 1'b1;
              state         <= RSP;
            end
          end
        end
        RD_WAIT: begin
          lat_cnt <= lat_cnt + 3'd1;
          // lat_cnt == RD_LAT marks the cycle the SRAM data is valid.
          if (lat_cnt == 3'(RD_LAT)) begin
            icb_rsp_rdata <= sram_rd_data;
            icb_rsp_err   <= 1'b0;
            icb_rsp_valid <= 1'b1;
            state         <= RSP;
          end
        end
        RSP: begin
          if (icb_rsp_ready) begin
            icb_rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icb_slave_bank.sv
// tb/tb_icb_slave_bank.sv - table-driven bench for icb_slave_bank with an SRAM model
module tb_icb_slave_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_addr;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic [31:0] icb_rsp_rdata;
  logic        icb_rsp_err;
  logic [63:0] cfg_regs;
  logic [1:0]  cfg_wr_pulse;
  logic [31:0] status_in;
  logic        sram_wr_en;
  logic [3:0]  sram_wr_be;
  logic [9:0]  sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic        sram_rd_en;
  logic [9:0]  sram_rd_addr;
  logic [31:0] sram_rd_data;

  always #5 clk = ~clk;

  icb_slave_bank dut (
    .clk(clk), .rst_n(rst_n),
    .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
    .icb_cmd_read(icb_cmd_read), .icb_cmd_addr(icb_cmd_addr),
    .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
    .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
    .icb_rsp_rdata(icb_rsp_rdata), .icb_rsp_err(icb_rsp_err),
    .cfg_regs(cfg_regs), .cfg_wr_pulse(cfg_wr_pulse), .status_in(status_in),
    .sram_wr_en(sram_wr_en), .sram_wr_be(sram_wr_be),
    .sram_wr_addr(sram_wr_addr), .sram_wr_data(sram_wr_data),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr),
    .sram_rd_data(sram_rd_data)
  );

  // SRAM with one cycle of read latency
  logic [31:0] mem [1024] = '{default: 32'h0};
  always @(posedge clk) begin
    if (sram_wr_en)
      for (int k = 0; k < 4; k++)
        if (sram_wr_be[k]) mem[sram_wr_addr][8*k +: 8] <= sram_wr_data[8*k +: 8];
    if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
  end

  int n_pulse = 0, n_wr = 0, n_rd = 0;
  always @(posedge clk) begin
    if (cfg_wr_pulse != 2'b00) n_pulse <= n_pulse + 1;
    if (sram_wr_en) n_wr <= n_wr + 1;
    if (sram_rd_en) n_rd <= n_rd + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        chk_rdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_np;
    logic [1:0]  exp_pulse;
    int          exp_nw;
    int          exp_nr;
    int          exp_saddr;
    logic [3:0]  exp_be;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int g = 0;
    while (!icb_cmd_ready && g < 20) begin
      tick();
      g++;
    end
    if (!icb_cmd_ready) chk({name, ".ready_timeout"}, 0, 1);
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int p0, w0, r0, lat;
    logic [1:0]  t1_pulse;
    logic [3:0]  t1_be;
    logic [9:0]  t1_waddr, t1_raddr;
    logic [31:0] t1_wdata;
    wait_ready(name);
    p0 = n_pulse; w0 = n_wr; r0 = n_rd;
    icb_cmd_valid = 1'b1;
    icb_cmd_read  = v.rd;
    icb_cmd_addr  = v.addr;
    icb_cmd_wdata = v.wdata;
    icb_cmd_wmask = v.wmask;
    tick();
    icb_cmd_valid = 1'b0;
    t1_pulse = cfg_wr_pulse; t1_be = sram_wr_be; t1_waddr = sram_wr_addr;
    t1_wdata = sram_wr_data; t1_raddr = sram_rd_addr;
    lat = 1;
    while (!icb_rsp_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk({name, ".lat"}, lat, v.exp_lat);
    chk({name, ".err"}, icb_rsp_err, v.exp_err);
    if (v.chk_rdata) chk({name, ".rdata"}, icb_rsp_rdata, v.exp_rdata);
    icb_rsp_ready = 1'b1;
    tick();
    icb_rsp_ready = 1'b0;
    tick();
    chk({name, ".n_pulse"}, n_pulse - p0, v.exp_np);
    chk({name, ".n_wr"}, n_wr - w0, v.exp_nw);
    chk({name, ".n_rd"}, n_rd - r0, v.exp_nr);
    if (v.exp_np != 0) chk({name, ".pulse"}, t1_pulse, v.exp_pulse);
    if (v.exp_nw != 0) begin
      chk({name, ".wr_addr"}, t1_waddr, v.exp_saddr);
      chk({name, ".wr_be"}, t1_be, v.exp_be);
      chk({name, ".wr_data"}, t1_wdata, v.wdata);
    end
    if (v.exp_nr != 0) chk({name, ".rd_addr"}, t1_raddr, v.exp_saddr);
  endtask

  vec_t vt[$];

  initial begin
    int hi;
    //         rd   addr          wdata         wm   chk  rdata         err lat np pulse nw nr saddr be
    vt.push_back('{1'b1, 32'h10042000, 32'h0,        4'h0, 1'b1, 32'h00000000, 1'b0, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b1, 32'h10042004, 32'h0,        4'h0, 1'b1, 32'h00000002, 1'b0, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b0, 32'h10042004, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0,        1'b0, 1, 1, 2'b10, 0, 0, 0,    4'h0});
    vt.push_back('{1'b1, 32'h10042004, 32'h0,        4'h0, 1'b1, 32'h00BB00DD, 1'b0, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b0, 32'h10042010, 32'h12345678, 4'hF, 1'b0, 32'h0,        1'b0, 1, 0, 2'b00, 1, 0, 1,    4'hF});
    vt.push_back('{1'b1, 32'h10042010, 32'h0,        4'h0, 1'b1, 32'h12345678, 1'b0, 3, 0, 2'b00, 0, 1, 1,    4'h0});
    vt.push_back('{1'b0, 32'h10042FFC, 32'hDEADBEEF, 4'h3, 1'b0, 32'h0,        1'b0, 1, 0, 2'b00, 1, 0, 1020, 4'h3});
    vt.push_back('{1'b1, 32'h10042FFC, 32'h0,        4'h0, 1'b1, 32'h0000BEEF, 1'b0, 3, 0, 2'b00, 0, 1, 1020, 4'h0});
    vt.push_back('{1'b1, 32'h10042008, 32'h0,        4'h0, 1'b1, 32'hCAFE0001, 1'b0, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b0, 32'h10042008, 32'h11111111, 4'hF, 1'b1, 32'h0,        1'b1, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b1, 32'h10042010, 32'h0,        4'h0, 1'b1, 32'h12345678, 1'b0, 3, 0, 2'b00, 0, 1, 1,    4'h0});
    vt.push_back('{1'b1, 32'h10043000, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b1, 32'h10042002, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b1, 32'h1004300C, 32'h0,        4'h0, 1'b1, 32'h0,        1'b1, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b0, 32'h10042000, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h0,        1'b0, 1, 1, 2'b01, 0, 0, 0,    4'h0});
    vt.push_back('{1'b1, 32'h10042000, 32'h0,        4'h0, 1'b1, 32'h00000000, 1'b0, 1, 0, 2'b00, 0, 0, 0,    4'h0});
    vt.push_back('{1'b0, 32'h10042000, 32'h11223344, 4'h8, 1'b0, 32'h0,        1'b0, 1, 1, 2'b01, 0, 0, 0,    4'h0});
    vt.push_back('{1'b1, 32'h10042000, 32'h0,        4'h0, 1'b1, 32'h11000000, 1'b0, 1, 0, 2'b00, 0, 0, 0,    4'h0});

    rst_n = 1'b0;
    icb_cmd_valid = 1'b0; icb_cmd_read = 1'b0; icb_cmd_addr = '0;
    icb_cmd_wdata = '0; icb_cmd_wmask = '0; icb_rsp_ready = 1'b0;
    status_in = 32'hCAFE0001;
    repeat (3) tick();
    chk("rst.cmd_ready", icb_cmd_ready, 1);
    chk("rst.rsp_valid", icb_rsp_valid, 0);
    chk("rst.cfg_regs", cfg_regs, 64'h00000002_00000000);
    chk("rst.rdata", icb_rsp_rdata, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < vt.size(); i++) run_vec(vt[i], $sformatf("v%0d", i));
    chk("cfg_after_vectors", cfg_regs, 64'h00BB00DD_11000000);

    // Response backpressure, then back-to-back command after the handshake
    wait_ready("bp");
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h10042004;
    tick();
    icb_cmd_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp.valid%0d", c), icb_rsp_valid, 1);
      chk($sformatf("bp.rdata%0d", c), icb_rsp_rdata, 32'h00BB00DD);
      chk($sformatf("bp.cmd_ready%0d", c), icb_cmd_ready, 0);
      tick();
    end
    icb_rsp_ready = 1'b1;
    icb_cmd_valid = 1'b1; icb_cmd_addr = 32'h10042000;
    tick();
    icb_rsp_ready = 1'b0;
    chk("bp.idle_ready", icb_cmd_ready, 1);
    chk("bp.idle_valid", icb_rsp_valid, 0);
    tick();
    icb_cmd_valid = 1'b0;
    chk("bp.second_valid", icb_rsp_valid, 1);
    chk("bp.second_rdata", icb_rsp_rdata, 32'h11000000);
    icb_rsp_ready = 1'b1;
    tick();
    icb_rsp_ready = 1'b0;

    // Reset while a SRAM read is in flight
    wait_ready("rw");
    icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h10042010;
    tick();
    icb_cmd_valid = 1'b0;
    chk("rw.in_wait", icb_rsp_valid, 0);
    rst_n = 1'b0;
    tick();
    chk("rw.rsp_valid", icb_rsp_valid, 0);
    chk("rw.cmd_ready", icb_cmd_ready, 1);
    chk("rw.cfg_regs", cfg_regs, 64'h00000002_00000000);
    rst_n = 1'b1;
    hi = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (icb_rsp_valid) hi++;
    end
    chk("rw.no_stale_rsp", hi, 0);
    run_vec('{1'b1, 32'h10042004, 32'h0, 4'h0, 1'b1, 32'h00000002, 1'b0, 1, 0, 2'b00, 0, 0, 0, 4'h0}, "rw.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
